mem_line_ctrl: RTL and testbench

Parametrised, synthesizable successor to the bus-2 memory controller. It sits on bus 2 behind the cache and owns a byte-addressed RAM. It serves C2_READ_LINE and C2_WRITE_LINE with configurable data-bus width, line size and access latency. Bus 2 is split into directional in/out/oe signals, so the top level builds the tristate, and the full cycle-accurate read path is included.

---
 rtl/bus2_pkg.sv | 29 ++
 rtl/mem_line_ctrl_if.sv | 22 ++
 rtl/mem_line_ram.sv | 35 +++
 rtl/mem_line_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_mem_line_ctrl.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/bus2_pkg.sv
// Bus-2 command codes, controller states and width helpers shared by the
// line controller, its RAM and its bus interface.
package bus2_pkg;

    typedef enum logic [1:0] {
        C2_NOP        = 2'd0,
        C2_RESPONSE   = 2'd1,
        C2_READ_LINE  = 2'd2,
        C2_WRITE_LINE = 2'd3
    } c2_cmd_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        W_DATA = 3'd1,
        W_WAIT = 3'd2,
        R_WAIT = 3'd3,
        R_DATA = 3'd4,
        RESP   = 3'd5
    } ctrl_state_e;

    function automatic int width_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mem_line_ctrl_if.sv
// Directional bus-2 signals between the cache (master) and the line controller
// (slave); the tristate is built from the *_oe strobes outside this block.
interface mem_line_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
);
    import bus2_pkg::*;

    logic [1:0]        c2_in;
    c2_cmd_e           c2_out;
    logic              c2_oe;
    logic [ADDR_W-1:0] a2_in;
    logic [DATA_W-1:0] d2_in;
    logic [DATA_W-1:0] d2_out;
    logic              d2_oe;
    logic              busy;

    modport slave  (input  c2_in, a2_in, d2_in,
                    output c2_out, c2_oe, d2_out, d2_oe, busy);
    modport master (output c2_in, a2_in, d2_in,
                    input  c2_out, c2_oe, d2_out, d2_oe, busy);
endinterface

// File: rtl/mem_line_ram.sv
// Byte-organised backing RAM with one beat-wide port: synchronous write,
// combinational read, little-endian byte lanes. Contents are never reset.
module mem_line_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16384,
    parameter int AW     = 14
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);
    localparam int BB = DATA_W / 8;

    logic [7:0] mem_q [DEPTH];

    // Beat write: lane i lands at addr+i
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < BB; i++) begin
                mem_q[addr + AW'(i)] <= wr_data[8*i +: 8];
            end
        end
    end

    // Beat read assembled from consecutive bytes
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < BB; i++) begin
            rd_data[8*i +: 8] = mem_q[addr + AW'(i)];
        end
    end

endmodule

// File: rtl/mem_line_ctrl.sv
// Bus-2 memory controller: serves READ_LINE / WRITE_LINE against a byte RAM
// with a fixed access latency, driving directional bus-2 outputs.
module mem_line_ctrl
    import bus2_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int LINE_BYTES = 16,
    parameter int ADDR_W     = 10,
    parameter int MEM_LINES  = 1024,
    parameter int MEM_DELAY  = 100
) (
    input  logic           CLK,
    input  logic           RESET,
    mem_line_ctrl_if.slave bus
);
    localparam int BEATS      = LINE_BYTES * 8 / DATA_W;
    localparam int BEAT_BYTES = DATA_W / 8;
    localparam int R_W        = max_of(MEM_DELAY, BEATS);
    localparam int R_R        = MEM_DELAY;
    localparam int BYTE_AW    = width_of(MEM_LINES * LINE_BYTES);
    localparam int BEAT_W     = $clog2(BEATS) + 1;
    localparam int DLY_W      = $clog2(R_W + 1) + 1;

    localparam logic [BEAT_W-1:0] BEATS_C = BEAT_W'(BEATS);
    localparam logic [DLY_W-1:0]  RW_LAST = DLY_W'(R_W - 1);
    localparam logic [DLY_W-1:0]  RR_LAST = DLY_W'(R_R - 1);
    localparam logic [DLY_W-1:0]  DLY_MAX = {DLY_W{1'b1}};

    ctrl_state_e        state_q, state_d;
    logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [DLY_W-1:0]   dly_q, dly_d;
    logic [BYTE_AW-1:0] base_q, base_d;
    c2_cmd_e            c2_out_q, c2_out_d;
    logic               c2_oe_q, c2_oe_d;
    logic [DATA_W-1:0]  d2_out_q, d2_out_d;
    logic               d2_oe_q, d2_oe_d;
    logic               busy_q, busy_d;

    logic [ADDR_W-1:0]  a2_s;
    logic [BYTE_AW-1:0] cmd_base_s;
    logic [BYTE_AW-1:0] ram_addr_s;
    logic               wr_en_s;
    logic [DATA_W-1:0]  rd_data_s;

    assign a2_s = bus.a2_in;

    // RAM address: command line base while idle, else latched base plus beat offset
    always_comb begin
        cmd_base_s = BYTE_AW'((32'(a2_s) % MEM_LINES) * LINE_BYTES);
        if (state_q == IDLE) begin
            ram_addr_s = cmd_base_s;
        end else begin
            ram_addr_s = base_q + BYTE_AW'(beat_cnt_q) * BYTE_AW'(BEAT_BYTES);
        end
    end

    mem_line_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (MEM_LINES * LINE_BYTES),
        .AW     (BYTE_AW)
    ) u_ram (
        .clk     (CLK),
        .wr_en   (wr_en_s),
        .addr    (ram_addr_s),
        .wr_data (bus.d2_in),
        .rd_data (rd_data_s)
    );

    // Next state, counters, RAM write strobe and next registered outputs
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        dly_d      = (dly_q == DLY_MAX) ? dly_q : dly_q + 1'b1;
        base_d     = base_q;
        wr_en_s    = 1'b0;
        d2_out_d   = '0;
        c2_out_d   = C2_NOP;
        c2_oe_d    = 1'b0;
        d2_oe_d    = 1'b0;

        case (state_q)
            IDLE: begin
                dly_d      = '0;
                beat_cnt_d = '0;
                case (bus.c2_in)
                    C2_WRITE_LINE: begin
                        // Beat 0 rides with the command
                        state_d    = W_DATA;
                        base_d     = cmd_base_s;
                        wr_en_s    = 1'b1;
                        beat_cnt_d = BEAT_W'(1);
                    end
                    C2_READ_LINE: begin
                        state_d = R_WAIT;
                        base_d  = cmd_base_s;
                    end
                    default: state_d = IDLE;
                endcase
            end
            W_DATA: begin
                if (beat_cnt_q < BEATS_C) begin
                    wr_en_s    = 1'b1;
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end else if (dly_q == RW_LAST) begin
                    state_d = RESP;
                end else begin
                    state_d = W_WAIT;
                end
            end
            W_WAIT: begin
                if (dly_q == RW_LAST) begin
                    state_d = RESP;
                end else begin
                    state_d = W_WAIT;
                end
            end
            R_WAIT: begin
                if (dly_q == RR_LAST) begin
                    state_d    = R_DATA;
                    d2_out_d   = rd_data_s;
                    beat_cnt_d = BEAT_W'(1);
                end else begin
                    state_d = R_WAIT;
                end
            end
            R_DATA: begin
                if (beat_cnt_q < BEATS_C) begin
                    d2_out_d   = rd_data_s;
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end else begin
                    state_d    = IDLE;
                    beat_cnt_d = '0;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        case (state_d)
            W_WAIT, R_WAIT: c2_oe_d = 1'b1;
            R_DATA: begin
                c2_oe_d  = 1'b1;
                c2_out_d = C2_RESPONSE;
                d2_oe_d  = 1'b1;
            end
            RESP: begin
                c2_oe_d  = 1'b1;
                c2_out_d = C2_RESPONSE;
            end
            default: c2_oe_d = 1'b0;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State, counters and registered bus outputs
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            dly_q      <= '0;
            base_q     <= '0;
            c2_out_q   <= C2_NOP;
            c2_oe_q    <= 1'b0;
            d2_out_q   <= '0;
            d2_oe_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            dly_q      <= dly_d;
            base_q     <= base_d;
            c2_out_q   <= c2_out_d;
            c2_oe_q    <= c2_oe_d;
            d2_out_q   <= d2_out_d;
            d2_oe_q    <= d2_oe_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.c2_out = c2_out_q;
    assign bus.c2_oe  = c2_oe_q;
    assign bus.d2_out = d2_out_q;
    assign bus.d2_oe  = d2_oe_q;
    assign bus.busy   = busy_q;

endmodule

// File: tb/tb_mem_line_ctrl.sv
// Bench for mem_line_ctrl: three configurations (long latency, short latency,
// wide bus) driven with directed and random line traffic against a byte model.
module tb_mem_line_ctrl;
    import bus2_pkg::*;

    localparam int DW_C [3] = '{16, 16, 64};
    localparam int LB_C [3] = '{16, 16, 16};
    localparam int ML_C [3] = '{1024, 40, 12};
    localparam int MD_C [3] = '{100, 2, 1};
    localparam int AW_C [3] = '{11, 6, 4};

    typedef struct packed {
        logic [1:0]  c2_out;
        logic        c2_oe;
        logic [63:0] d2_out;
        logic        d2_oe;
        logic        busy;
    } obs_t;

    logic CLK;
    logic RESET;
    int   vectors;
    int   miscompares;
    logic [7:0] model_mem [int];

    mem_line_ctrl_if #(.ADDR_W(11), .DATA_W(16)) if0 ();
    mem_line_ctrl_if #(.ADDR_W(6),  .DATA_W(16)) if1 ();
    mem_line_ctrl_if #(.ADDR_W(4),  .DATA_W(64)) if2 ();

    mem_line_ctrl #(.DATA_W(16), .LINE_BYTES(16), .ADDR_W(11), .MEM_LINES(1024), .MEM_DELAY(100))
        dut0 (.CLK(CLK), .RESET(RESET), .bus(if0.slave));
    mem_line_ctrl #(.DATA_W(16), .LINE_BYTES(16), .ADDR_W(6), .MEM_LINES(40), .MEM_DELAY(2))
        dut1 (.CLK(CLK), .RESET(RESET), .bus(if1.slave));
    mem_line_ctrl #(.DATA_W(64), .LINE_BYTES(16), .ADDR_W(4), .MEM_LINES(12), .MEM_DELAY(1))
        dut2 (.CLK(CLK), .RESET(RESET), .bus(if2.slave));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input int w, input logic [1:0] c2, input int a2, input logic [63:0] d2);
        case (w)
            0: begin if0.c2_in = c2; if0.a2_in = 11'(a2); if0.d2_in = d2[15:0]; end
            1: begin if1.c2_in = c2; if1.a2_in = 6'(a2);  if1.d2_in = d2[15:0]; end
            default: begin if2.c2_in = c2; if2.a2_in = 4'(a2); if2.d2_in = d2; end
        endcase
    endtask

    function automatic obs_t sample(input int w);
        obs_t o;
        case (w)
            0: o = '{2'(if0.c2_out), if0.c2_oe, 64'(if0.d2_out), if0.d2_oe, if0.busy};
            1: o = '{2'(if1.c2_out), if1.c2_oe, 64'(if1.d2_out), if1.d2_oe, if1.busy};
            default: o = '{2'(if2.c2_out), if2.c2_oe, if2.d2_out, if2.d2_oe, if2.busy};
        endcase
        return o;
    endfunction

    // Byte address of beat k of the line named by a2 (line index wraps)
    function automatic int beat_addr(input int w, input int a2, input int k);
        return w * 65536 + (a2 % ML_C[w]) * LB_C[w] + k * (DW_C[w] / 8);
    endfunction

    task automatic model_store(input int w, input int a2, input int k, input logic [63:0] d);
        for (int b = 0; b < DW_C[w] / 8; b++) model_mem[beat_addr(w, a2, k) + b] = d[8*b +: 8];
    endtask

    function automatic logic [63:0] model_beat(input int w, input int a2, input int k);
        logic [63:0] v;
        v = '0;
        for (int b = 0; b < DW_C[w] / 8; b++) v[8*b +: 8] = model_mem[beat_addr(w, a2, k) + b];
        return v;
    endfunction

    task automatic abort_reset(input int w);
        obs_t o;
        RESET = 1'b0;
        #1;
        o = sample(w);
        chk("rst_c2_oe", 64'(o.c2_oe), 64'd0);
        chk("rst_d2_oe", 64'(o.d2_oe), 64'd0);
        chk("rst_busy", 64'(o.busy), 64'd0);
        chk("rst_c2_out", 64'(o.c2_out), 64'(C2_NOP));
        drive(w, C2_NOP, 0, 64'd0);
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    // Command driven before edge T0; iteration n observes the cycle after edge T0+n
    task automatic do_write(input int w, input int a2, input bit directed, input int abort_n);
        obs_t o;
        int beats, rw;
        logic [63:0] d [8];
        beats = LB_C[w] * 8 / DW_C[w];
        rw    = (MD_C[w] > beats) ? MD_C[w] : beats;
        for (int k = 0; k < beats; k++) d[k] = directed ? 64'(16'h1100 + k) : {$urandom, $urandom};
        drive(w, C2_WRITE_LINE, a2, d[0]);
        for (int n = 0; n <= rw + 1; n++) begin
            @(negedge CLK);
            if (n < beats) model_store(w, a2, n, d[n]);
            o = sample(w);
            if (n <= rw) begin
                chk("wr_busy", 64'(o.busy), 64'd1);
            end else begin
                chk("wr_end_busy", 64'(o.busy), 64'd0);
                chk("wr_end_c2_oe", 64'(o.c2_oe), 64'd0);
            end
            if (n >= beats && n < rw) begin
                chk("wr_wait_c2_oe", 64'(o.c2_oe), 64'd1);
                chk("wr_wait_cmd", 64'(o.c2_out), 64'(C2_NOP));
            end
            if (n == rw) begin
                chk("wr_resp_c2_oe", 64'(o.c2_oe), 64'd1);
                chk("wr_resp_cmd", 64'(o.c2_out), 64'(C2_RESPONSE));
            end
            chk("wr_d2_oe", 64'(o.d2_oe), 64'd0);
            if (n == abort_n) begin
                abort_reset(w);
                return;
            end
            drive(w, C2_NOP, a2, (n + 1 < beats) ? d[n + 1] : {$urandom, $urandom});
        end
    endtask

    task automatic do_read(input int w, input int a2, input int drop_n, input int abort_n);
        obs_t o;
        int beats, rr;
        beats = LB_C[w] * 8 / DW_C[w];
        rr    = MD_C[w];
        drive(w, C2_READ_LINE, a2, {$urandom, $urandom});
        for (int n = 0; n <= rr + beats; n++) begin
            @(negedge CLK);
            o = sample(w);
            if (n < rr + beats) begin
                chk("rd_busy", 64'(o.busy), 64'd1);
            end else begin
                chk("rd_end_busy", 64'(o.busy), 64'd0);
                chk("rd_end_c2_oe", 64'(o.c2_oe), 64'd0);
                chk("rd_end_d2_oe", 64'(o.d2_oe), 64'd0);
            end
            if (n >= 1 && n < rr) begin
                chk("rd_wait_c2_oe", 64'(o.c2_oe), 64'd1);
                chk("rd_wait_cmd", 64'(o.c2_out), 64'(C2_NOP));
                chk("rd_wait_d2_oe", 64'(o.d2_oe), 64'd0);
            end
            if (n >= rr && n < rr + beats) begin
                chk("rd_data_c2_oe", 64'(o.c2_oe), 64'd1);
                chk("rd_data_cmd", 64'(o.c2_out), 64'(C2_RESPONSE));
                chk("rd_data_d2_oe", 64'(o.d2_oe), 64'd1);
                chk("rd_data", o.d2_out, model_beat(w, a2, n - rr));
            end
            if (n == abort_n) begin
                abort_reset(w);
                return;
            end
            drive(w, (n == drop_n) ? 2'(C2_WRITE_LINE) : 2'(C2_NOP), a2, {$urandom, $urandom});
        end
    endtask

    initial begin
        obs_t o;
        vectors     = 0;
        miscompares = 0;
        RESET       = 1'b0;
        for (int w = 0; w < 3; w++) drive(w, C2_NOP, 0, 64'd0);
        repeat (3) @(negedge CLK);
        for (int w = 0; w < 3; w++) begin
            o = sample(w);
            chk("reset_c2_out", 64'(o.c2_out), 64'(C2_NOP));
            chk("reset_c2_oe", 64'(o.c2_oe), 64'd0);
            chk("reset_d2_out", o.d2_out, 64'd0);
            chk("reset_d2_oe", 64'(o.d2_oe), 64'd0);
            chk("reset_busy", 64'(o.busy), 64'd0);
        end
        RESET = 1'b1;
        @(negedge CLK);

        // Directed round trip, wrap alias, dropped command and back-to-back reads
        do_write(0, 5, 1'b1, -1);
        do_read(0, 5, -1, -1);
        do_write(0, 1024 + 3, 1'b0, -1);
        do_read(0, 3, -1, -1);
        do_read(0, 5, 10, -1);
        do_read(0, 5, -1, -1);

        // Reset during the data phase of a read, then a normal read
        do_read(0, 3, -1, 102);
        do_read(0, 3, -1, -1);

        // Reset after four beats of a write: only those beats change
        do_write(1, 7, 1'b0, -1);
        do_write(1, 7, 1'b0, 3);
        do_read(1, 7, -1, -1);

        // Random traffic on the short-latency and wide-bus configurations
        for (int i = 0; i < 12; i++) begin
            for (int w = 1; w < 3; w++) begin
                int line, a2w, a2r;
                line = int'($urandom_range(0, ML_C[w] - 1));
                a2w  = line;
                a2r  = line;
                if (line + ML_C[w] < (1 << AW_C[w])) begin
                    if ($urandom_range(0, 1) == 1) a2w = line + ML_C[w];
                    else a2r = line + ML_C[w];
                end
                do_write(w, a2w, 1'b0, -1);
                do_read(w, a2r, -1, -1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
